// File: rtl/toy_fetch_filter_if.sv
// Handshake bundle between the icache response path, the fetch filter and
// the fetch queue. The master modport is the filter itself; the slave
// modport is the surrounding environment (icache and fetch queue).
interface toy_fetch_filter_if #(
  parameter int FILTER_CHANNEL = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int EPOCH_WIDTH    = 2
);
  localparam int LANE_W = $clog2(FILTER_CHANNEL);

  // icache response channel
  logic                                line_vld;
  logic                                line_rdy;
  logic [ADDR_WIDTH-1:0]               line_pc;
  logic [FILTER_CHANNEL*INST_WIDTH-1:0] line_data;
  logic [EPOCH_WIDTH-1:0]              line_epoch;
  logic                                line_taken;
  logic [LANE_W-1:0]                   line_taken_lane;

  // filtered line channel into the fetch queue
  logic                                        filter_vld;
  logic                                        filter_rdy;
  logic [FILTER_CHANNEL-1:0][ADDR_WIDTH-1:0]   filter_pc;
  logic [FILTER_CHANNEL-1:0][INST_WIDTH-1:0]   filter_inst;
  logic [FILTER_CHANNEL-1:0]                   filter_en;

  modport master (
    input  line_vld, line_pc, line_data, line_epoch, line_taken, line_taken_lane,
    output line_rdy,
    output filter_vld, filter_pc, filter_inst, filter_en,
    input  filter_rdy
  );

  modport slave (
    output line_vld, line_pc, line_data, line_epoch, line_taken, line_taken_lane,
    input  line_rdy,
    input  filter_vld, filter_pc, filter_inst, filter_en,
    output filter_rdy
  );
endinterface

// File: rtl/toy_fetch_filter.sv
// Fetch filter: masks lanes outside [start offset, taken branch], drops
// lines tagged with a stale fetch epoch, and holds the result in a
// single-entry full-throughput output register feeding the fetch queue.
module toy_fetch_filter #(
  parameter int FILTER_CHANNEL = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int EPOCH_WIDTH    = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cancel_en,
  toy_fetch_filter_if.master        bus,
  output logic [EPOCH_WIDTH-1:0]    cur_epoch,
  output logic [DROP_CNT_WIDTH-1:0] stale_drop_cnt
);
  localparam int LANE_W   = $clog2(FILTER_CHANNEL);
  localparam int LINE_LSB = LANE_W + 2;   // 4-byte lanes

  typedef enum logic [2:0] {
    ACT_NONE,    // nothing accepted, no pop
    ACT_POP,     // entry leaves, nothing replaces it
    ACT_CANCEL,  // flush: clear entry, bump epoch, discard any accepted line
    ACT_STALE,   // accepted line from an old epoch
    ACT_EMPTY,   // accepted line with no surviving lane
    ACT_LOAD     // accepted line written into the register
  } act_e;

  logic                                      accept;
  logic [LANE_W-1:0]                         lane_off;
  logic [FILTER_CHANNEL-1:0]                 lane_mask;
  logic [FILTER_CHANNEL-1:0][ADDR_WIDTH-1:0] lane_pc;
  act_e                                      act;

  assign lane_off     = bus.line_pc[LINE_LSB-1:2];
  assign bus.line_rdy = ~bus.filter_vld | bus.filter_rdy;
  assign accept       = bus.line_vld & bus.line_rdy;

  // Per-lane enable and PC derived from the fetch start and the taken lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_mask = '0;
    lane_pc   = '0;
    for (int i = 0; i < FILTER_CHANNEL; i++) begin
      lane_mask[i] = (LANE_W'(i) >= lane_off) &&
                     (!bus.line_taken || (LANE_W'(i) <= bus.line_taken_lane));
      lane_pc[i]   = {bus.line_pc[ADDR_WIDTH-1:LINE_LSB], LANE_W'(i), 2'b00};
    end
  end

  // Classify this cycle's event; cancel outranks everything else.
  always_comb begin
    act = ACT_NONE;
    if (cancel_en) begin
      act = ACT_CANCEL;
    end else if (accept) begin
      if (bus.line_epoch != cur_epoch) begin
        act = ACT_STALE;
      end else if (lane_mask == '0) begin
        act = ACT_EMPTY;
      end else begin
        act = ACT_LOAD;
      end
    end else if (bus.filter_vld && bus.filter_rdy) begin
      act = ACT_POP;
    end
  end

  // Output register, epoch and stale-drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide lane registers are reset too, because the fetch queue may observe them right after reset.
      bus.filter_vld  <= 1'b0;
      bus.filter_en   <= '0;
      bus.filter_pc   <= '0;
      bus.filter_inst <= '0;
      cur_epoch       <= '0;
      stale_drop_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (act)
        ACT_CANCEL: begin
          bus.filter_vld <= 1'b0;
          bus.filter_en  <= '0;
          cur_epoch      <= cur_epoch + 1'b1;
        end
        ACT_STALE: begin
          // An accept implies the old entry was absent or popped this cycle.
          bus.filter_vld <= 1'b0;
          if (stale_drop_cnt != '1) stale_drop_cnt <= stale_drop_cnt + 1'b1;
        end
        ACT_EMPTY: begin
          bus.filter_vld  <= 1'b0;
          bus.filter_en   <= lane_mask;
          bus.filter_pc   <= lane_pc;
          bus.filter_inst <= bus.line_data;
        end
        ACT_LOAD: begin
          bus.filter_vld  <= 1'b1;
          bus.filter_en   <= lane_mask;
          bus.filter_pc   <= lane_pc;
          bus.filter_inst <= bus.line_data;
        end
        ACT_POP:  bus.filter_vld <= 1'b0;
        default:  ;
      endcase
    end
  end
endmodule
